counter_ramp_scheduler: RTL and testbench
=========================================

Name: counter_ramp_scheduler

Overview:
- Shares one WIDTH-bit up/down/load counter among NUM_REQ requesters.
- Each requester submits either a target value or a direct load. A round-robin arbiter picks one request at a time.
- A small FSM then issues a single load or a series of single-step up/down pulses until the counter equals the target, and signals completion to the granted requester.
- Sits directly in front of the counter and drives its load/up/down/In pins.

Parameters:
- WIDTH, 4, counter and target width in bits.
- NUM_REQ, 4, number of requesters (≥2).
- MAX_STEPS, 20, ramp watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid; held high until accepted.
- req_load  in  NUM_REQ  per-requester mode: 1 = direct load, 0 = ramp.
- req_target  in  NUM_REQ*WIDTH  per-requester target; slice i = bits [i*WIDTH +: WIDTH].
- req_ready  out  NUM_REQ  one-hot accept pulse.
- req_done  out  NUM_REQ  one-hot completion pulse.
- cnt_count  in  WIDTH  current counter value.
- cnt_load  out  1  counter load strobe.
- cnt_up  out  1  counter increment strobe.
- cnt_down  out  1  counter decrement strobe.
- cnt_in  out  WIDTH  counter load data.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- States: IDLE, LOAD, RAMP, DONE.
- Reset (rst=1 at clk edge), regardless of state:
  - state=IDLE, rr_ptr=0, grant_id=0, target_q=0.
  - All strobes 0, req_ready=0, req_done=0, busy=0, cnt_in=0.
  - An in-flight command is dropped without a done pulse.
- IDLE:
  - Round-robin search over req_valid, starting at rr_ptr.
  - On a hit at index i: req_ready[i]=1 combinationally in the same cycle. On the edge: latch target_q, mode_q and grant_id=i; set rr_ptr=(i+1) mod NUM_REQ.
  - Next state is LOAD if req_load[i]=1, otherwise RAMP.
  - No request pending: stay in IDLE with no outputs.
- LOAD:
  - cnt_load=1 and cnt_in=target_q for exactly one cycle, then go to DONE.
- RAMP: one comparison per cycle of cnt_count against target_q, combinational outputs.
  - Equal: no strobe; go to DONE.
  - cnt_count < target_q: cnt_up=1.
  - cnt_count > target_q: cnt_down=1.
  - The counter updates on the same edge, so the next comparison sees the new value. Overshoot is impossible and no wrap-around path is taken.
- DONE:
  - req_done[grant_id]=1 for one cycle, then go to IDLE.
- Timing: ramp from c to t takes |t-c| step cycles, plus 1 compare cycle, plus 1 DONE cycle.
- Acceptance:
  - Requests are accepted only in IDLE; minimum spacing between accepts is 3 cycles.
  - req_valid deasserting before acceptance is legal (request withdrawn).
  - Inputs of an accepted request are not sampled again after acceptance.
- Output rules:
  - At most one of cnt_load/cnt_up/cnt_down is high in any cycle.
  - cnt_in=target_q in LOAD, 0 otherwise.
- Target equal to the current count in ramp mode: no strobes; done 2 cycles after accept.

Optional Feature:
- Macro: COUNTER_RAMP_SCHED_WDOG_EN.
- Enabled:
  - Adds output wdog_err (1 bit, reset 0) and a step counter cleared on entry to RAMP.
  - If the step counter reaches MAX_STEPS while still in RAMP (e.g. the counter is being driven externally), the FSM goes to DONE. wdog_err pulses together with that req_done.
- Disabled:
  - No port, no step counter; RAMP runs until equal.

Decomposition:
- Shared package counter_sched_pkg holds:
  - state enum sched_state_e {IDLE, LOAD, RAMP, DONE};
  - a localparam for the default WIDTH.
- One sub-module, rr_arbiter (NUM_REQ parameter):
  - Inputs: req vector, ptr, enable.
  - Outputs: one-hot grant, grant index, hit flag.
  - Purely combinational.
- The pointer register, FSM and the optional watchdog live in the top.

Test Plan:
- Reset then ramp: cnt_count=0, req_valid[0], req_load=0, target=5 -> ready[0] in cycle 0; cnt_up high 5 cycles; done[0] 2 cycles after the last up; busy low the next cycle.
- Direct load: cnt_count=3, req1 load, target=12 -> cnt_load=1 with cnt_in=12 for exactly 1 cycle, then done[1]; no up/down pulses.
- Down ramp: count=15, target=2 -> 13 cnt_down pulses, then done; no up pulses.
- Round-robin fairness: all 4 requesters held valid with target = current count -> grant order 0,1,2,3,0; each done 2 cycles after its ready.
- Reset mid-ramp: rst in the 3rd up cycle of a ramp 0->10 -> next cycle all outputs 0, busy=0, no req_done, rr_ptr=0.
- Watchdog (with COUNTER_RAMP_SCHED_WDOG_EN, MAX_STEPS=20): model forces count to hold at 0, target=8 -> 20 up cycles, then req_done and wdog_err pulse together.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared types for the counter ramp scheduler: FSM state encoding and default width.
package counter_sched_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RAMP = 2'd2,
    DONE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       hit
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    int                cand;
    logic [IDX_W-1:0]  cand_idx;
    grant     = '0;
    grant_idx = '0;
    hit       = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Wrap the search so the scan covers every requester exactly once.
      cand     = (int'(ptr) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (enable && !hit && req[cand_idx]) begin
        hit             = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/counter_ramp_scheduler.sv
// Arbitrates NUM_REQ requesters onto one up/down/load counter, ramping or loading to target.
// Optional ramp watchdog enabled by defining COUNTER_RAMP_SCHED_WDOG_EN.
module counter_ramp_scheduler
  import counter_sched_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int NUM_REQ   = 4,
  parameter int MAX_STEPS = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_load,
  input  logic [NUM_REQ*WIDTH-1:0]   req_target,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         req_done,
  input  logic [WIDTH-1:0]           cnt_count,
  output logic                       cnt_load,
  output logic                       cnt_up,
  output logic                       cnt_down,
  output logic [WIDTH-1:0]           cnt_in,
  output logic                       busy,
`ifdef COUNTER_RAMP_SCHED_WDOG_EN
  output logic                       wdog_err,
`endif
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_id_q, grant_id_d;
  logic [WIDTH-1:0] target_q, target_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_hit;

`ifdef COUNTER_RAMP_SCHED_WDOG_EN
  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  logic [STEP_W-1:0] step_q, step_d;
  logic              wdog_q, wdog_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .enable    (state_q == IDLE),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .hit       (arb_hit)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    target_d   = target_q;
    req_ready  = arb_grant;
    req_done   = '0;
    cnt_load   = 1'b0;
    cnt_up     = 1'b0;
    cnt_down   = 1'b0;
    cnt_in     = '0;
`ifdef COUNTER_RAMP_SCHED_WDOG_EN
    step_d     = step_q;
    wdog_d     = wdog_q;
    wdog_err   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (arb_hit) begin
          target_d   = req_target[arb_idx*WIDTH +: WIDTH];
          grant_id_d = arb_idx;
          rr_ptr_d   = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
          state_d    = req_load[arb_idx] ? LOAD : RAMP;
`ifdef COUNTER_RAMP_SCHED_WDOG_EN
          step_d     = '0;
          wdog_d     = 1'b0;
`endif
        end
      end
      LOAD: begin
        cnt_load = 1'b1;
        cnt_in   = target_q;
        state_d  = DONE;
      end
      RAMP: begin
        // Normal completion takes priority over a watchdog expiry in the same cycle.
        if (cnt_count == target_q) begin
          state_d = DONE;
`ifdef COUNTER_RAMP_SCHED_WDOG_EN
        end else if (step_q == STEP_W'(MAX_STEPS)) begin
          state_d = DONE;
          wdog_d  = 1'b1;
`endif
        end else begin
          cnt_up   = (cnt_count < target_q);
          cnt_down = (cnt_count > target_q);
`ifdef COUNTER_RAMP_SCHED_WDOG_EN
          step_d   = step_q + 1'b1;
`endif
        end
      end
      DONE: begin
        req_done[grant_id_q] = 1'b1;
        state_d              = IDLE;
`ifdef COUNTER_RAMP_SCHED_WDOG_EN
        wdog_err             = wdog_q;
        wdog_d               = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      target_q   <= '0;
`ifdef COUNTER_RAMP_SCHED_WDOG_EN
      step_q     <= '0;
      wdog_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      target_q   <= target_d;
`ifdef COUNTER_RAMP_SCHED_WDOG_EN
      step_q     <= step_d;
      wdog_q     <= wdog_d;
`endif
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_counter_ramp_scheduler.sv
// Directed self-checking bench for counter_ramp_scheduler with a behavioural counter model.
module tb_counter_ramp_scheduler;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_load, req_ready, req_done;
  logic [N*W-1:0] req_target;
  logic [W-1:0]   cnt_count, cnt_in;
  logic           cnt_load, cnt_up, cnt_down, busy;
  logic [1:0]     grant_id;
`ifdef COUNTER_RAMP_SCHED_WDOG_EN
  logic           wdog_err;
`endif

  always #5 clk = ~clk;

  counter_ramp_scheduler #(.WIDTH(W), .NUM_REQ(N), .MAX_STEPS(20)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_load   (req_load),
    .req_target (req_target),
    .req_ready  (req_ready),
    .req_done   (req_done),
    .cnt_count  (cnt_count),
    .cnt_load   (cnt_load),
    .cnt_up     (cnt_up),
    .cnt_down   (cnt_down),
    .cnt_in     (cnt_in),
    .busy       (busy),
`ifdef COUNTER_RAMP_SCHED_WDOG_EN
    .wdog_err   (wdog_err),
`endif
    .grant_id   (grant_id)
  );

  // Counter the scheduler drives; can be preset or frozen by the bench.
  logic         cnt_set_en = 1'b0;
  logic [W-1:0] cnt_set_val = '0;
  logic         cnt_hold = 1'b0;
  always @(posedge clk) begin
    if (cnt_set_en)      cnt_count <= cnt_set_val;
    else if (!cnt_hold) begin
      if (cnt_load)      cnt_count <= cnt_in;
      else if (cnt_up)   cnt_count <= cnt_count + 1'b1;
      else if (cnt_down) cnt_count <= cnt_count - 1'b1;
    end
  end

  logic [N-1:0] rdy_log [64];
  logic [N-1:0] done_log[64];
  logic         up_log  [64];
  logic         dn_log  [64];
  logic         ld_log  [64];
  logic [W-1:0] in_log  [64];
  logic         busy_log[64];
  logic         wd_log  [64];
  bit           auto_drop = 1'b1;
  int           tests_run = 0;
  int           tests_failed = 0;

  // Entered and left at posedge+1; samples at negedge, requesters drop valid once accepted.
  task automatic run_cycles(input int n);
    logic [N-1:0] r;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      rdy_log[c]  = req_ready;
      done_log[c] = req_done;
      up_log[c]   = cnt_up;
      dn_log[c]   = cnt_down;
      ld_log[c]   = cnt_load;
      in_log[c]   = cnt_in;
      busy_log[c] = busy;
`ifdef COUNTER_RAMP_SCHED_WDOG_EN
      wd_log[c]   = wdog_err;
`else
      wd_log[c]   = 1'b0;
`endif
      r = req_ready;
      @(posedge clk); #1;
      if (auto_drop) req_valid = req_valid & ~r;
    end
  endtask

  function automatic int count_log(input int sel, input int n);
    int s = 0;
    for (int c = 0; c < n; c++) begin
      case (sel)
        0: s += int'(up_log[c]);
        1: s += int'(dn_log[c]);
        2: s += int'(ld_log[c]);
        default: s += int'(wd_log[c]);
      endcase
    end
    return s;
  endfunction

  task automatic set_cnt(input logic [W-1:0] v);
    cnt_set_en  = 1'b1;
    cnt_set_val = v;
    @(posedge clk); #1;
    cnt_set_en  = 1'b0;
  endtask

  task automatic set_req(input int i, input logic ld, input logic [W-1:0] tgt);
    req_valid[i]          = 1'b1;
    req_load[i]           = ld;
    req_target[i*W +: W]  = tgt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_valid = '0; req_load = '0; req_target = '0;
    cnt_set_en = 1'b1; cnt_set_val = '0;
    do_reset();
    cnt_set_en = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, req_ready, req_done, cnt_load, cnt_up, cnt_down, cnt_in} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got busy=%b rdy=%b done=%b ld/up/dn=%b%b%b in=%0d want all 0",
               busy, req_ready, req_done, cnt_load, cnt_up, cnt_down, cnt_in);
    end
    tests_run++;
    if (grant_id !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_grant_id: got %0d want 0", grant_id);
    end
    @(posedge clk); #1;
    $display("[TB] test_reset complete");
  endtask

  task automatic test_up_ramp();
    set_cnt(4'd0);
    set_req(0, 1'b0, 4'd5);
    run_cycles(9);
    tests_run++;
    if (rdy_log[0] !== 4'b0001) begin
      tests_failed++; $display("FAIL up_ready: got %b want 0001", rdy_log[0]);
    end
    tests_run++;
    if (count_log(0, 9) !== 5 || up_log[1] !== 1'b1 || up_log[5] !== 1'b1) begin
      tests_failed++; $display("FAIL up_pulses: got %0d want 5 in cycles 1..5", count_log(0, 9));
    end
    tests_run++;
    if (done_log[7] !== 4'b0001 || done_log[6] !== 4'b0000) begin
      tests_failed++; $display("FAIL up_done: got c6=%b c7=%b want 0000 0001", done_log[6], done_log[7]);
    end
    tests_run++;
    if (busy_log[8] !== 1'b0 || busy_log[7] !== 1'b1) begin
      tests_failed++; $display("FAIL up_busy: got c7=%b c8=%b want 1 0", busy_log[7], busy_log[8]);
    end
    tests_run++;
    if (cnt_count !== 4'd5) begin
      tests_failed++; $display("FAIL up_final_count: got %0d want 5", cnt_count);
    end
    $display("[TB] test_up_ramp complete");
  endtask

  task automatic test_direct_load();
    set_cnt(4'd3);
    set_req(1, 1'b1, 4'd12);
    run_cycles(4);
    tests_run++;
    if (rdy_log[0] !== 4'b0010) begin
      tests_failed++; $display("FAIL load_ready: got %b want 0010", rdy_log[0]);
    end
    tests_run++;
    if (ld_log[1] !== 1'b1 || in_log[1] !== 4'd12 || count_log(2, 4) !== 1) begin
      tests_failed++; $display("FAIL load_strobe: got ld=%b in=%0d n=%0d want 1 12 1",
                                ld_log[1], in_log[1], count_log(2, 4));
    end
    tests_run++;
    if (in_log[2] !== 4'd0 || in_log[0] !== 4'd0) begin
      tests_failed++; $display("FAIL load_cnt_in_idle: got c0=%0d c2=%0d want 0 0", in_log[0], in_log[2]);
    end
    tests_run++;
    if (done_log[2] !== 4'b0010 || count_log(0, 4) + count_log(1, 4) !== 0) begin
      tests_failed++; $display("FAIL load_done: got done=%b steps=%0d want 0010 0",
                                done_log[2], count_log(0, 4) + count_log(1, 4));
    end
    tests_run++;
    if (cnt_count !== 4'd12 || grant_id !== 2'd1) begin
      tests_failed++; $display("FAIL load_result: got cnt=%0d gid=%0d want 12 1", cnt_count, grant_id);
    end
    $display("[TB] test_direct_load complete");
  endtask

  task automatic test_down_ramp();
    set_cnt(4'd15);
    set_req(2, 1'b0, 4'd2);
    run_cycles(17);
    tests_run++;
    if (rdy_log[0] !== 4'b0100) begin
      tests_failed++; $display("FAIL down_ready: got %b want 0100", rdy_log[0]);
    end
    tests_run++;
    if (count_log(1, 17) !== 13 || count_log(0, 17) !== 0) begin
      tests_failed++; $display("FAIL down_pulses: got down=%0d up=%0d want 13 0",
                                count_log(1, 17), count_log(0, 17));
    end
    tests_run++;
    if (done_log[15] !== 4'b0100 || cnt_count !== 4'd2) begin
      tests_failed++; $display("FAIL down_done: got done=%b cnt=%0d want 0100 2", done_log[15], cnt_count);
    end
    $display("[TB] test_down_ramp complete");
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_oh [5];
    exp_oh[0] = 4'b0001; exp_oh[1] = 4'b0010; exp_oh[2] = 4'b0100;
    exp_oh[3] = 4'b1000; exp_oh[4] = 4'b0001;
    do_reset();
    set_cnt(4'd7);
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'd7);
    auto_drop = 1'b0;
    run_cycles(15);
    req_valid = '0;
    auto_drop = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tests_run++;
      if (rdy_log[3*g] !== exp_oh[g] || done_log[3*g+2] !== exp_oh[g]) begin
        tests_failed++;
        $display("FAIL rr_grant%0d: got ready=%b done=%b want %b", g, rdy_log[3*g], done_log[3*g+2], exp_oh[g]);
      end
    end
    tests_run++;
    if (count_log(0, 15) + count_log(1, 15) + count_log(2, 15) !== 0) begin
      tests_failed++; $display("FAIL rr_no_strobes: got %0d strobes want 0",
                                count_log(0, 15) + count_log(1, 15) + count_log(2, 15));
    end
    $display("[TB] test_round_robin complete");
  endtask

  task automatic test_reset_mid_ramp();
    set_cnt(4'd0);
    set_req(1, 1'b0, 4'd10);
    run_cycles(3);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (cnt_up !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_third_up: got %b want 1", cnt_up);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({busy, req_ready, req_done, cnt_load, cnt_up, cnt_down, cnt_in, grant_id} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: got busy=%b done=%b up=%b gid=%0d want all 0",
               busy, req_done, cnt_up, grant_id);
    end
    @(posedge clk); #1;
    set_cnt(4'd0);
    set_req(1, 1'b0, 4'd0);
    set_req(3, 1'b0, 4'd0);
    run_cycles(6);
    tests_run++;
    if (rdy_log[0] !== 4'b0010 || done_log[2] !== 4'b0010 || rdy_log[3] !== 4'b1000) begin
      tests_failed++; $display("FAIL midrst_rr_ptr: got r0=%b d2=%b r3=%b want 0010 0010 1000",
                                rdy_log[0], done_log[2], rdy_log[3]);
    end
    $display("[TB] test_reset_mid_ramp complete");
  endtask

`ifdef COUNTER_RAMP_SCHED_WDOG_EN
  task automatic test_watchdog();
    set_cnt(4'd0);
    cnt_hold = 1'b1;
    set_req(0, 1'b0, 4'd8);
    run_cycles(23);
    cnt_hold = 1'b0;
    tests_run++;
    if (count_log(0, 23) !== 20 || up_log[21] !== 1'b0) begin
      tests_failed++; $display("FAIL wdog_up_pulses: got %0d want 20", count_log(0, 23));
    end
    tests_run++;
    if (done_log[22] !== 4'b0001 || wd_log[22] !== 1'b1 || count_log(3, 23) !== 1) begin
      tests_failed++; $display("FAIL wdog_done: got done=%b err=%b n=%0d want 0001 1 1",
                                done_log[22], wd_log[22], count_log(3, 23));
    end
    $display("[TB] test_watchdog complete");
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0; req_load = '0; req_target = '0;
    test_reset();
    test_up_ramp();
    test_direct_load();
    test_down_ramp();
    test_round_robin();
    test_reset_mid_ramp();
`ifdef COUNTER_RAMP_SCHED_WDOG_EN
    test_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
